ch376_host_fifo: RTL and testbench

CH376_HOST_FIFO -- requirements
Module: ch376_host_fifo

---
 rtl/ch376_pkg.sv | 38 +++
 rtl/sync_fifo8.sv | 73 +++++++
 rtl/ch376_host_fifo.sv | 196 +++++++++++++++++++
 tb/tb_ch376_host_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch376_pkg.sv
// Shared definitions for the CH376 host FIFO bridge.
//   - link_state_e : link sequencer state encodings
//   - STS_*        : bit positions in the CPU status byte
//   - CTL_*        : bit positions in the CPU control byte
package ch376_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4
  } link_state_e;

  // Status byte, MSB first: {rx_en, rx_ovf, tx_ovf, busy, rx_full, rx_empty, tx_full, tx_empty}
  localparam int unsigned STS_TX_EMPTY = 0;
  localparam int unsigned STS_TX_FULL  = 1;
  localparam int unsigned STS_RX_EMPTY = 2;
  localparam int unsigned STS_RX_FULL  = 3;
  localparam int unsigned STS_BUSY     = 4;
  localparam int unsigned STS_TX_OVF   = 5;
  localparam int unsigned STS_RX_OVF   = 6;
  localparam int unsigned STS_RX_EN    = 7;

  // Control byte
  localparam int unsigned CTL_FLUSH   = 0;
  localparam int unsigned CTL_CLR_OVF = 1;
  localparam int unsigned CTL_RX_EN   = 2;

  localparam int unsigned DATA_W = 8;

  // Cycles spent in WAIT_BUSY when the link never drops ready
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned BUSY_CNT_W   = 2;

  localparam logic [DATA_W-1:0] RX_EMPTY_BYTE = 8'hFF;

endpackage

// File: rtl/sync_fifo8.sv
// Byte-wide synchronous FIFO used for both the TX and RX queues.
// Ports:
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   flush_i          : empties the FIFO, overrides push/pop in that cycle
//   push_i, din_i    : write request and data
//   pop_i            : read request (ignored when empty)
//   dout_o           : head entry (valid when not empty)
//   full_o, empty_o  : occupancy flags
//   drop_o           : push rejected because the FIFO is full and not popping
module sync_fifo8 #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        pop_ok;
  logic        push_ok;

  // Extra pointer MSB distinguishes full from empty
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;
  assign drop_o  = push_i & full_o & ~pop_ok & ~flush_i;

  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; empty/full come from the pointers only
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ch376_host_fifo.sv
// CPU-to-SPI-link bridge for a CH376: buffers CPU writes in a TX FIFO, ships
// each byte over the link, and queues the byte returned per transfer in an RX FIFO.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   cpu_rd, cpu_wr       : level strobes, acted on once per assertion
//   cpu_a0               : 0 = data, 1 = status/control
//   cpu_din / cpu_dout   : CPU data in / combinational read data
//   link_wr, link_din    : one-cycle transfer start with byte to send
//   link_rd, link_dout   : one-cycle capture acknowledge with received byte
//   link_ready           : link idle
module ch376_host_fifo
  import ch376_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              cpu_a0,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              link_wr,
  output logic [DATA_W-1:0] link_din,
  output logic              link_rd,
  input  logic [DATA_W-1:0] link_dout,
  input  logic              link_ready
);

  link_state_e state_q, state_d;
  logic [BUSY_CNT_W-1:0] cnt_q, cnt_d;

  logic wr_q, rd_q;
  logic rd_a0_q, rd_a0_d;
  logic tx_ovf_q, tx_ovf_d;
  logic rx_ovf_q, rx_ovf_d;
  logic rx_en_q, rx_en_d;
  logic link_wr_q, link_wr_d;
  logic link_rd_q, link_rd_d;
  logic [DATA_W-1:0] link_din_q, link_din_d;

  logic wr_rise, rd_fall;
  logic data_wr, ctl_wr, flush, clr_ovf;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_full, tx_empty, tx_drop;
  logic rx_full, rx_empty, rx_drop;
  logic [DATA_W-1:0] tx_dout, rx_dout;
  logic busy;
  logic [DATA_W-1:0] status;

  // CPU strobe decode: writes act on the rising edge, reads on the falling edge
  assign wr_rise = cpu_wr & ~wr_q;
  assign rd_fall = ~cpu_rd & rd_q;
  assign data_wr = wr_rise & ~cpu_a0;
  assign ctl_wr  = wr_rise & cpu_a0;
  assign flush   = ctl_wr & cpu_din[CTL_FLUSH];
  assign clr_ovf = ctl_wr & cpu_din[CTL_CLR_OVF];

  // FIFO request mapping
  assign tx_push = data_wr;
  assign tx_pop  = (state_q == ST_ISSUE);
  assign rx_push = (state_q == ST_CAPTURE) & rx_en_q;
  // Register select was latched while cpu_rd was high; a0 may have moved since
  assign rx_pop  = rd_fall & ~rd_a0_q;

  assign busy = (state_q != ST_IDLE);

  sync_fifo8 #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (flush),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (cpu_din),
    .dout_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .drop_o  (tx_drop)
  );

  sync_fifo8 #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (flush),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .din_i   (link_dout),
    .dout_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .drop_o  (rx_drop)
  );

  // Status byte assembly
  always_comb begin
    status               = '0;
    status[STS_TX_EMPTY] = tx_empty;
    status[STS_TX_FULL]  = tx_full;
    status[STS_RX_EMPTY] = rx_empty;
    status[STS_RX_FULL]  = rx_full;
    status[STS_BUSY]     = busy;
    status[STS_TX_OVF]   = tx_ovf_q;
    status[STS_RX_OVF]   = rx_ovf_q;
    status[STS_RX_EN]    = rx_en_q;
  end

  // CPU read mux
  always_comb begin
    cpu_dout = '0;
    if (cpu_rd) begin
      if (cpu_a0)        cpu_dout = status;
      else if (rx_empty) cpu_dout = RX_EMPTY_BYTE;
      else               cpu_dout = rx_dout;
    end
  end

  // Control/status register next-state; a new overflow wins over a same-cycle clear
  always_comb begin
    rd_a0_d  = cpu_rd ? cpu_a0 : rd_a0_q;
    tx_ovf_d = (tx_ovf_q & ~clr_ovf) | tx_drop;
    rx_ovf_d = (rx_ovf_q & ~clr_ovf) | rx_drop;
    rx_en_d  = ctl_wr ? cpu_din[CTL_RX_EN] : rx_en_q;
  end

  // Link sequencer next-state; link outputs are registered against the next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    link_din_d = link_din_q;
    unique case (state_q)
      ST_IDLE: begin
        // Do not launch from a FIFO that is being flushed this cycle
        if (!tx_empty && link_ready && !flush) begin
          state_d    = ST_ISSUE;
          link_din_d = tx_dout;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end
      ST_WAIT_BUSY: begin
        // Fall through after a fixed wait in case the busy phase was too short to see
        if (!link_ready || cnt_q == BUSY_CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + BUSY_CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (link_ready) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    link_wr_d = (state_d == ST_ISSUE);
    link_rd_d = (state_d == ST_CAPTURE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rd_a0_q    <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      rx_en_q    <= 1'b1;
      link_wr_q  <= 1'b0;
      link_rd_q  <= 1'b0;
      link_din_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= cpu_wr;
      rd_q       <= cpu_rd;
      rd_a0_q    <= rd_a0_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      rx_en_q    <= rx_en_d;
      link_wr_q  <= link_wr_d;
      link_rd_q  <= link_rd_d;
      link_din_q <= link_din_d;
    end
  end

  assign link_wr  = link_wr_q;
  assign link_rd  = link_rd_q;
  assign link_din = link_din_q;

endmodule

// File: tb/tb_ch376_host_fifo.sv
module tb_ch376_host_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_rd, cpu_wr, cpu_a0;
  logic [7:0] cpu_din, cpu_dout;
  logic       link_wr, link_rd, link_ready;
  logic [7:0] link_din, link_dout;

  int vectors = 0;
  int errors  = 0;

  // Link model: drops ready after each link_wr, returns resp_base + transfer number
  logic       m_ready = 1'b1;
  logic [7:0] m_dout  = 8'h00;
  int         busy_left = 0;
  int         wr_count  = 0;
  logic [7:0] tx_log[$];
  logic       tb_block;
  int         link_delay;
  logic [7:0] resp_base;

  assign link_ready = m_ready & ~tb_block;
  assign link_dout  = m_dout;

  always #5 clk = ~clk;

  ch376_host_fifo #(.DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_a0     (cpu_a0),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .link_wr    (link_wr),
    .link_din   (link_din),
    .link_rd    (link_rd),
    .link_dout  (link_dout),
    .link_ready (link_ready)
  );

  always @(negedge clk) begin
    if (link_wr) begin
      tx_log.push_back(link_din);
      wr_count  = wr_count + 1;
      m_ready   = 1'b0;
      busy_left = link_delay;
    end else if (!m_ready) begin
      if (busy_left > 1) begin
        busy_left = busy_left - 1;
      end else begin
        m_dout  = resp_base + 8'(wr_count);
        m_ready = 1'b1;
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_write(input logic a0, input logic [7:0] d);
    @(negedge clk);
    cpu_a0  = a0;
    cpu_din = d;
    cpu_wr  = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic do_read(input logic a0, input int hold, input logic [7:0] exp, input string name);
    @(negedge clk);
    cpu_a0 = a0;
    cpu_rd = 1'b1;
    #1;
    check8(name, cpu_dout, exp);
    repeat (hold) @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  // Next transfer's returned byte will be 'first', then first+1, ...
  task automatic set_resp(input logic [7:0] first);
    resp_base = first - 8'(wr_count + 1);
  endtask

  task automatic wait_wr(input int target, input string name);
    int n;
    n = 0;
    while (wr_count < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (wr_count < target) begin
      errors++;
      $display("FAIL %s: link_wr count %0d expected %0d (timeout)", name, wr_count, target);
    end
    repeat (20) @(negedge clk);
  endtask

  // Launch one transfer, then keep the link busy until tb_block is released
  task automatic start_held_transfer(input logic [7:0] d);
    do_write(1'b0, d);
    @(negedge clk);
    tb_block = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic       is_rd;
    logic       a0;
    logic [7:0] data;
    string      name;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;

    tbl[0]  = '{1'b1, 1'b1, 8'h85, "reset status"};
    tbl[1]  = '{1'b1, 1'b0, 8'hFF, "empty rx read"};
    tbl[2]  = '{1'b0, 1'b0, 8'h11, "push tx"};
    tbl[3]  = '{1'b1, 1'b1, 8'h84, "status tx not empty"};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, "ctl rx_en off"};
    tbl[5]  = '{1'b1, 1'b1, 8'h04, "status rx_en off"};
    tbl[6]  = '{1'b0, 1'b1, 8'h04, "ctl rx_en on"};
    tbl[7]  = '{1'b1, 1'b1, 8'h84, "status rx_en on"};
    tbl[8]  = '{1'b0, 1'b0, 8'h22, "push tx 2"};
    tbl[9]  = '{1'b0, 1'b1, 8'h05, "ctl flush"};
    tbl[10] = '{1'b1, 1'b1, 8'h85, "status after flush"};
    tbl[11] = '{1'b1, 1'b0, 8'hFF, "rx read after flush"};

    reset      = 1'b1;
    cpu_rd     = 1'b0;
    cpu_wr     = 1'b0;
    cpu_a0     = 1'b0;
    cpu_din    = 8'h00;
    tb_block   = 1'b1;
    link_delay = 2;
    resp_base  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check8("reset link_wr", {7'd0, link_wr}, 8'h00);
    check8("reset link_rd", {7'd0, link_rd}, 8'h00);
    check8("reset link_din", link_din, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check8("idle cpu_dout", cpu_dout, 8'h00);

    // Register behaviour with the link stalled (FSM stays idle)
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_rd) do_read(tbl[i].a0, 1, tbl[i].data, tbl[i].name);
      else              do_write(tbl[i].a0, tbl[i].data);
    end

    // Single transfer, link busy for 8 cycles, returns 0xA5
    tb_block   = 1'b0;
    link_delay = 8;
    set_resp(8'hA5);
    wc = wr_count;
    do_write(1'b0, 8'h57);
    wait_wr(wc + 1, "single xfer");
    check_int("single xfer count", tx_log.size(), wc + 1);
    check8("single xfer byte", tx_log[wc], 8'h57);
    do_read(1'b0, 1, 8'hA5, "rx returned byte");
    do_read(1'b0, 1, 8'hFF, "rx empty after pop");

    // 17 writes with the link busy: overflow, then 16 go out in order
    tb_block   = 1'b1;
    link_delay = 2;
    for (int i = 0; i < 17; i++) do_write(1'b0, 8'(i));
    do_read(1'b1, 1, 8'hA6, "status tx full ovf");
    wc = wr_count;
    set_resp(8'h40);
    @(negedge clk);
    tb_block = 1'b0;
    wait_wr(wc + 16, "16 xfers");
    check_int("16 xfer count", tx_log.size(), wc + 16);
    for (int i = 0; i < 16; i++) check8("tx order", tx_log[wc + i], 8'(i));
    do_read(1'b1, 1, 8'hA9, "status rx full");
    do_write(1'b1, 8'h06);
    do_read(1'b1, 1, 8'h89, "status ovf cleared");

    // RX full: capture and CPU pop land in the same cycle
    set_resp(8'h50);
    start_held_transfer(8'h77);
    @(negedge clk);
    cpu_a0 = 1'b0;
    cpu_rd = 1'b1;
    #1;
    check8("rx head while full", cpu_dout, 8'h40);
    @(negedge clk);
    tb_block = 1'b0;
    @(negedge clk);
    check8("capture cycle link_rd", {7'd0, link_rd}, 8'h01);
    cpu_rd = 1'b0;
    do_read(1'b1, 1, 8'h89, "full pop+push status");
    // Held read strobe pops exactly once
    do_read(1'b0, 10, 8'h41, "held read");
    for (int i = 2; i < 16; i++) do_read(1'b0, 1, 8'(8'h40 + i), "rx drain");
    do_read(1'b0, 1, 8'h50, "rx drain last");
    do_read(1'b0, 1, 8'hFF, "rx drained");
    do_read(1'b1, 1, 8'h85, "status drained");

    // Flush with 5 bytes queued while a transfer is in flight
    wc = wr_count;
    start_held_transfer(8'h61);
    for (int i = 2; i <= 6; i++) do_write(1'b0, 8'(8'h60 + i));
    do_read(1'b1, 1, 8'h94, "status mid xfer");
    do_write(1'b1, 8'h01);
    do_read(1'b1, 1, 8'h15, "status after flush busy");
    @(negedge clk);
    tb_block = 1'b0;
    repeat (30) @(negedge clk);
    do_read(1'b1, 1, 8'h05, "status after capture");
    check_int("flush xfer count", tx_log.size(), wc + 1);
    check8("flush xfer byte", tx_log[wc], 8'h61);
    do_read(1'b0, 1, 8'hFF, "rx empty rx_en off");

    // Reset in WAIT_DONE
    do_write(1'b1, 8'h04);
    do_read(1'b1, 1, 8'h85, "status rx_en back on");
    start_held_transfer(8'h33);
    @(negedge clk);
    reset  = 1'b1;
    cpu_a0 = 1'b1;
    cpu_rd = 1'b1;
    #1;
    check8("reset mid link_wr", {7'd0, link_wr}, 8'h00);
    check8("reset mid link_rd", {7'd0, link_rd}, 8'h00);
    check8("reset mid status", cpu_dout, 8'h85);
    @(negedge clk);
    reset  = 1'b0;
    cpu_rd = 1'b0;
    wc = wr_count;
    tb_block = 1'b0;
    repeat (10) @(negedge clk);
    check_int("no xfer after reset", wr_count, wc);
    do_read(1'b1, 1, 8'h85, "status after reset");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
